// File: rtl/ctrl_regs_axi_lite_initiator.sv
// AXI-Lite initiator for the control-register slave: single writes/reads plus masked poll; cmd->rsp 3 cycles at zero wait.
// One transaction in flight; cmd_ready only in IDLE, rsp held until rsp_ready_i, AXI valids held until their ready.
package ctrl_regs_axi_lite_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  prot;
  } ax_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
  } w_chan_t;

  typedef struct packed {
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    logic    ar_ready;
    r_chan_t r;
    logic    r_valid;
  } resp_t;
endpackage

module ctrl_regs_axi_lite_initiator #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned MaxPolls  = 1024,
  parameter int unsigned PollGap   = 4,
  parameter type axi_lite_req_t  = ctrl_regs_axi_lite_pkg::req_t,
  parameter type axi_lite_resp_t = ctrl_regs_axi_lite_pkg::resp_t
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             cmd_valid_i,
  output logic                             cmd_ready_o,
  input  logic                             cmd_write_i,
  input  logic                             cmd_poll_i,
  input  logic [AddrWidth-1:0]             cmd_addr_i,
  input  logic [DataWidth-1:0]             cmd_wdata_i,
  input  logic [DataWidth/8-1:0]           cmd_strb_i,
  input  logic [DataWidth-1:0]             cmd_mask_i,
  input  logic [DataWidth-1:0]             cmd_match_i,
  output logic                             rsp_valid_o,
  input  logic                             rsp_ready_i,
  output logic [DataWidth-1:0]             rsp_rdata_o,
  output logic                             rsp_error_o,
  output logic                             rsp_timeout_o,
  output logic [$clog2(MaxPolls+1)-1:0]    rsp_polls_o,
  output axi_lite_req_t                    axi_lite_master_req_o,
  input  axi_lite_resp_t                   axi_lite_master_resp_i
);

  localparam int PollW = $clog2(MaxPolls + 1);
  localparam int GapW  = (PollGap > 1) ? $clog2(PollGap) : 1;
  localparam logic [PollW-1:0] PollMax = PollW'(MaxPolls);
  localparam logic [GapW-1:0]  GapLast = GapW'((PollGap > 0) ? (PollGap - 1) : 0);

  typedef enum logic [2:0] {
    IDLE, WR, WAIT_B, RD_AR, WAIT_R, GAP, RESP
  } state_e;

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic                   r_write;
  logic                   r_poll;
  logic [AddrWidth-1:0]   r_addr;
  logic [DataWidth-1:0]   r_wdata;
  logic [DataWidth/8-1:0] r_strb;
  logic [DataWidth-1:0]   r_mask;
  logic [DataWidth-1:0]   r_match;
  logic                   r_aw_done;
  logic                   r_w_done;
  logic [PollW-1:0]       r_poll_cnt;
  logic [GapW-1:0]        r_gap_cnt;
  logic [DataWidth-1:0]   r_rdata;
  logic                   r_error;
  logic                   r_timeout;

  logic w_cmd_hs;
  logic w_aw_vld, w_w_vld, w_b_rdy, w_ar_vld, w_r_rdy;
  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic w_aw_fin, w_w_fin;
  logic w_r_err, w_match, w_poll_max;
  logic w_unused;

  assign w_cmd_hs   = cmd_valid_i && (r_state == IDLE);
  assign w_aw_vld   = (r_state == WR) && !r_aw_done;
  assign w_w_vld    = (r_state == WR) && !r_w_done;
  assign w_b_rdy    = (r_state == WR) || (r_state == WAIT_B);
  assign w_ar_vld   = (r_state == RD_AR);
  assign w_r_rdy    = (r_state == WAIT_R);

  assign w_aw_hs    = w_aw_vld && axi_lite_master_resp_i.aw_ready;
  assign w_w_hs     = w_w_vld  && axi_lite_master_resp_i.w_ready;
  assign w_b_hs     = w_b_rdy  && axi_lite_master_resp_i.b_valid;
  assign w_ar_hs    = w_ar_vld && axi_lite_master_resp_i.ar_ready;
  assign w_r_hs     = w_r_rdy  && axi_lite_master_resp_i.r_valid;
  assign w_aw_fin   = r_aw_done || w_aw_hs;
  assign w_w_fin    = r_w_done  || w_w_hs;

  assign w_r_err    = axi_lite_master_resp_i.r.resp[1];
  assign w_match    = ((axi_lite_master_resp_i.r.data ^ r_match) & r_mask) == '0;
  assign w_poll_max = (r_poll_cnt == PollMax);
  assign w_unused   = ^{axi_lite_master_resp_i.r.resp[0], axi_lite_master_resp_i.b.resp[0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_write    <= 1'b0;
      r_poll     <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_strb     <= '0;
      r_mask     <= '0;
      r_match    <= '0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_poll_cnt <= '0;
      r_gap_cnt  <= '0;
      r_rdata    <= '0;
      r_error    <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cmd_hs) begin
        r_write    <= cmd_write_i;
        r_poll     <= cmd_poll_i && !cmd_write_i;
        r_addr     <= cmd_addr_i;
        r_wdata    <= cmd_wdata_i;
        r_strb     <= cmd_strb_i;
        r_mask     <= cmd_mask_i;
        r_match    <= cmd_match_i;
        r_aw_done  <= 1'b0;
        r_w_done   <= 1'b0;
        r_poll_cnt <= '0;
        r_rdata    <= '0;
        r_error    <= 1'b0;
        r_timeout  <= 1'b0;
      end
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;
      if (w_b_hs)  r_error   <= axi_lite_master_resp_i.b.resp[1];
      if (w_ar_hs && !w_poll_max) r_poll_cnt <= r_poll_cnt + 1'b1;
      if (w_r_hs) begin
        r_rdata   <= axi_lite_master_resp_i.r.data;
        r_error   <= w_r_err;
        r_timeout <= r_poll && !w_r_err && !w_match && w_poll_max;
      end
      // Gap counter runs only while parked in GAP and restarts on every entry.
      if (r_state == GAP) r_gap_cnt <= r_gap_cnt + 1'b1;
      else                r_gap_cnt <= '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:   if (cmd_valid_i) w_state_nxt = cmd_write_i ? WR : RD_AR;
      WR: begin
        if (w_aw_fin && w_w_fin) w_state_nxt = w_b_hs ? RESP : WAIT_B;
      end
      WAIT_B: if (w_b_hs) w_state_nxt = RESP;
      RD_AR:  if (w_ar_hs) w_state_nxt = WAIT_R;
      WAIT_R: begin
        if (w_r_hs) begin
          if (!r_poll || w_r_err || w_match || w_poll_max) w_state_nxt = RESP;
          else if (PollGap == 0)                           w_state_nxt = RD_AR;
          else                                             w_state_nxt = GAP;
        end
      end
      GAP:    if (r_gap_cnt == GapLast) w_state_nxt = RD_AR;
      RESP:   if (rsp_ready_i) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    axi_lite_master_req_o          = '0;
    axi_lite_master_req_o.aw.addr  = r_addr;
    axi_lite_master_req_o.aw.prot  = '0;
    axi_lite_master_req_o.aw_valid = w_aw_vld;
    axi_lite_master_req_o.w.data   = r_wdata;
    axi_lite_master_req_o.w.strb   = r_strb;
    axi_lite_master_req_o.w_valid  = w_w_vld;
    axi_lite_master_req_o.b_ready  = w_b_rdy;
    axi_lite_master_req_o.ar.addr  = r_addr;
    axi_lite_master_req_o.ar.prot  = '0;
    axi_lite_master_req_o.ar_valid = w_ar_vld;
    axi_lite_master_req_o.r_ready  = w_r_rdy;
  end

  assign cmd_ready_o   = (r_state == IDLE);
  assign rsp_valid_o   = (r_state == RESP);
  assign rsp_rdata_o   = r_rdata;
  assign rsp_error_o   = r_error;
  assign rsp_timeout_o = r_timeout;
  assign rsp_polls_o   = r_poll_cnt;

endmodule

// File: tb/tb_ctrl_regs_axi_lite_initiator.sv
// Bench for ctrl_regs_axi_lite_initiator: scripted scenarios plus randomized commands against a reference model.
module tb_ctrl_regs_axi_lite_initiator;
  import ctrl_regs_axi_lite_pkg::*;

  localparam int MP = 4;
  localparam int PG = 2;
  localparam int PW = $clog2(MP + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0, cmd_poll = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0, cmd_mask = '0, cmd_match = '0;
  logic [3:0]  cmd_strb = '0;
  logic        rsp_ready = 1'b0;
  logic        cmd_ready, rsp_valid, rsp_error, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [PW-1:0] rsp_polls;
  req_t        req;
  resp_t       rsp = '0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ctrl_regs_axi_lite_initiator #(
    .AddrWidth(32), .DataWidth(32), .MaxPolls(MP), .PollGap(PG),
    .axi_lite_req_t(req_t), .axi_lite_resp_t(resp_t)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_poll_i(cmd_poll), .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .cmd_strb_i(cmd_strb), .cmd_mask_i(cmd_mask), .cmd_match_i(cmd_match),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_error_o(rsp_error), .rsp_timeout_o(rsp_timeout), .rsp_polls_o(rsp_polls),
    .axi_lite_master_req_o(req), .axi_lite_master_resp_i(rsp)
  );

  // Slave configuration (written by tests only)
  int          aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
  logic [1:0]  b_resp_cfg = 2'b00;
  logic [31:0] rd_data_q[$];
  logic [1:0]  rd_resp_q[$];

  // Slave state and logs (written by the slave only)
  int aw_w = 0, w_w = 0, b_w = 0, ar_w = 0, r_w = 0;
  bit aw_got = 0, w_got = 0, r_pend = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, rd_ptr = 0;
  int aw_vld_cyc = 0, w_vld_cyc = 0;
  logic [31:0] last_awaddr = '0, last_wdata = '0, last_araddr = '0;
  logic [3:0]  last_wstrb = '0;
  int ar_cyc_q[$];

  // DUT valids are registered, so what is seen at the falling edge holds through the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      rsp = '0;
      aw_w = 0; w_w = 0; b_w = 0; ar_w = 0; r_w = 0;
      aw_got = 0; w_got = 0; r_pend = 0;
    end else begin
      rsp.b_valid = 1'b0;
      if (aw_got && w_got) begin
        if (b_w >= b_wait) begin
          rsp.b_valid = 1'b1;
          rsp.b.resp  = b_resp_cfg;
          if (req.b_ready) begin b_cnt++; aw_got = 0; w_got = 0; b_w = 0; end
        end else b_w++;
      end
      rsp.r_valid = 1'b0;
      if (r_pend) begin
        if (r_w >= r_wait) begin
          rsp.r_valid = 1'b1;
          rsp.r.data  = (rd_ptr < rd_data_q.size()) ? rd_data_q[rd_ptr] : 32'h0;
          rsp.r.resp  = (rd_ptr < rd_resp_q.size()) ? rd_resp_q[rd_ptr] : 2'b00;
          if (req.r_ready) begin rd_ptr++; r_pend = 0; r_w = 0; end
        end else r_w++;
      end
      rsp.aw_ready = 1'b0;
      if (req.aw_valid) begin
        aw_vld_cyc++;
        if (aw_w >= aw_wait) begin
          rsp.aw_ready = 1'b1; aw_cnt++; last_awaddr = req.aw.addr; aw_got = 1; aw_w = 0;
        end else aw_w++;
      end else aw_w = 0;
      rsp.w_ready = 1'b0;
      if (req.w_valid) begin
        w_vld_cyc++;
        if (w_w >= w_wait) begin
          rsp.w_ready = 1'b1; w_cnt++; last_wdata = req.w.data; last_wstrb = req.w.strb;
          w_got = 1; w_w = 0;
        end else w_w++;
      end else w_w = 0;
      rsp.ar_ready = 1'b0;
      if (req.ar_valid) begin
        if (ar_w >= ar_wait) begin
          rsp.ar_ready = 1'b1; ar_cnt++; last_araddr = req.ar.addr;
          ar_cyc_q.push_back(cyc); r_pend = 1; ar_w = 0;
        end else ar_w++;
      end else ar_w = 0;
    end
  end

  task automatic load_reads(input logic [31:0] d[$], input logic [1:0] r[$]);
    while (rd_data_q.size() > rd_ptr) void'(rd_data_q.pop_back());
    while (rd_resp_q.size() > rd_ptr) void'(rd_resp_q.pop_back());
    while (rd_resp_q.size() < rd_data_q.size()) rd_resp_q.push_back(2'b00);
    foreach (d[i]) begin rd_data_q.push_back(d[i]); rd_resp_q.push_back(r[i]); end
  endtask

  task automatic run_cmd(input logic wr, input logic pl, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         input logic [31:0] mask, input logic [31:0] match,
                         output logic [31:0] rdata, output logic err, output logic to,
                         output logic [PW-1:0] polls, output int lat);
    int n;
    int start;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_poll = pl; cmd_addr = addr;
    cmd_wdata = wdata; cmd_strb = strb; cmd_mask = mask; cmd_match = match;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    start = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 500) begin @(negedge clk); n++; end
    tests++;
    if (rsp_valid !== 1'b1) begin
      fails++;
      $display("FAIL rsp_timeout_wait: rsp_valid=%b after %0d cycles, required 1", rsp_valid, n);
    end
    lat = cyc - start;
    rdata = rsp_rdata; err = rsp_error; to = rsp_timeout; polls = rsp_polls;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic set_waits(input int a, input int w, input int b, input int ar, input int r);
    aw_wait = a; w_wait = w; b_wait = b; ar_wait = ar; r_wait = r;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++; $display("FAIL reset_hs: cmd_ready=%b rsp_valid=%b, required 1/0", cmd_ready, rsp_valid);
    end
    tests++;
    if ({req.aw_valid, req.w_valid, req.ar_valid, req.b_ready, req.r_ready} !== 5'b0) begin
      fails++; $display("FAIL reset_axi: aw/w/ar/b/r=%b, required 00000",
        {req.aw_valid, req.w_valid, req.ar_valid, req.b_ready, req.r_ready});
    end
    tests++;
    if (rsp_rdata !== 32'h0 || rsp_error !== 1'b0 || rsp_timeout !== 1'b0 || rsp_polls !== '0) begin
      fails++; $display("FAIL reset_rsp: rdata=%h err=%b to=%b polls=%0d, required zeros",
        rsp_rdata, rsp_error, rsp_timeout, rsp_polls);
    end
  endtask

  task automatic test_write();
    logic [31:0] rd; logic er, to; logic [PW-1:0] pl; int lat; int aw0;
    set_waits(0, 0, 0, 0, 0); b_resp_cfg = 2'b00; aw0 = aw_cnt;
    run_cmd(1'b1, 1'b0, 32'h0, 32'h0000_0003, 4'hF, 32'h0, 32'h0, rd, er, to, pl, lat);
    tests++;
    if (aw_cnt - aw0 !== 1 || last_awaddr !== 32'h0 || last_wdata !== 32'h3 || last_wstrb !== 4'hF) begin
      fails++; $display("FAIL write_beat: n=%0d addr=%h data=%h strb=%h, required 1/0/3/f",
        aw_cnt - aw0, last_awaddr, last_wdata, last_wstrb);
    end
    tests++;
    if (er !== 1'b0 || pl !== '0 || rd !== 32'h0 || to !== 1'b0) begin
      fails++; $display("FAIL write_rsp: err=%b polls=%0d rdata=%h to=%b, required 0/0/0/0", er, pl, rd, to);
    end
    tests++;
    if (lat !== 3) begin fails++; $display("FAIL write_latency: %0d, required 3", lat); end
  endtask

  task automatic test_read();
    logic [31:0] rd; logic er, to; logic [PW-1:0] pl; int lat;
    logic [31:0] d[$]; logic [1:0] r[$];
    set_waits(0, 0, 0, 0, 0);
    d = '{32'h8000_0000}; r = '{2'b00}; load_reads(d, r);
    run_cmd(1'b0, 1'b0, 32'hC, 32'h0, 4'h0, 32'h0, 32'h0, rd, er, to, pl, lat);
    tests++;
    if (rd !== 32'h8000_0000 || er !== 1'b0 || pl !== PW'(1) || last_araddr !== 32'hC) begin
      fails++; $display("FAIL read_rsp: rdata=%h err=%b polls=%0d araddr=%h, required 80000000/0/1/c",
        rd, er, pl, last_araddr);
    end
    tests++;
    if (lat !== 3) begin fails++; $display("FAIL read_latency: %0d, required 3", lat); end
  endtask

  task automatic test_poll_match();
    logic [31:0] rd; logic er, to; logic [PW-1:0] pl; int lat; int a0;
    logic [31:0] d[$]; logic [1:0] r[$];
    set_waits(0, 0, 0, 0, 0);
    d = '{32'h0, 32'h0, 32'h1}; r = '{2'b00, 2'b00, 2'b00}; load_reads(d, r);
    a0 = ar_cnt;
    run_cmd(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h1, 32'h1, rd, er, to, pl, lat);
    tests++;
    if (ar_cnt - a0 !== 3 || pl !== PW'(3) || to !== 1'b0 || rd !== 32'h1 || er !== 1'b0) begin
      fails++; $display("FAIL poll_match: ars=%0d polls=%0d to=%b rdata=%h err=%b, required 3/3/0/1/0",
        ar_cnt - a0, pl, to, rd, er);
    end
    for (int i = 1; i < 3; i++) begin
      tests++;
      if (ar_cyc_q[a0 + i] - ar_cyc_q[a0 + i - 1] !== 2 + PG) begin
        fails++; $display("FAIL poll_spacing: gap %0d = %0d cycles, required %0d",
          i, ar_cyc_q[a0 + i] - ar_cyc_q[a0 + i - 1], 2 + PG);
      end
    end
  endtask

  task automatic test_poll_timeout();
    logic [31:0] rd; logic er, to; logic [PW-1:0] pl; int lat; int a0;
    logic [31:0] d[$]; logic [1:0] r[$];
    set_waits(0, 0, 0, 1, 1);
    d = '{0, 0, 0, 0, 0, 0}; r = '{0, 0, 0, 0, 0, 0}; load_reads(d, r);
    a0 = ar_cnt;
    run_cmd(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h1, 32'h1, rd, er, to, pl, lat);
    tests++;
    if (ar_cnt - a0 !== MP || pl !== PW'(MP) || to !== 1'b1 || er !== 1'b0) begin
      fails++; $display("FAIL poll_timeout: ars=%0d polls=%0d to=%b err=%b, required %0d/%0d/1/0",
        ar_cnt - a0, pl, to, er, MP, MP);
    end
    repeat (10) @(negedge clk);
    tests++;
    if (ar_cnt - a0 !== MP || req.ar_valid !== 1'b0) begin
      fails++; $display("FAIL poll_after_timeout: ars=%0d arvalid=%b, required %0d/0", ar_cnt - a0, req.ar_valid, MP);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er, to; logic [PW-1:0] pl; int lat; int av0, wv0, b0;
    set_waits(2, 0, 0, 0, 0); b_resp_cfg = 2'b00;
    av0 = aw_vld_cyc; wv0 = w_vld_cyc; b0 = b_cnt;
    run_cmd(1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 4'h5, 32'h0, 32'h0, rd, er, to, pl, lat);
    tests++;
    if (aw_vld_cyc - av0 !== 3 || w_vld_cyc - wv0 !== 1 || b_cnt - b0 !== 1) begin
      fails++; $display("FAIL write_bp: awvld=%0d wvld=%0d b=%0d, required 3/1/1",
        aw_vld_cyc - av0, w_vld_cyc - wv0, b_cnt - b0);
    end
    tests++;
    if (er !== 1'b0 || last_wdata !== 32'hDEAD_BEEF || last_wstrb !== 4'h5) begin
      fails++; $display("FAIL write_bp_data: err=%b data=%h strb=%h, required 0/deadbeef/5", er, last_wdata, last_wstrb);
    end
    set_waits(0, 3, 1, 0, 0); b_resp_cfg = 2'b10;
    run_cmd(1'b1, 1'b0, 32'h14, 32'h1, 4'hF, 32'h0, 32'h0, rd, er, to, pl, lat);
    tests++;
    if (er !== 1'b1 || pl !== '0) begin
      fails++; $display("FAIL write_slverr: err=%b polls=%0d, required 1/0", er, pl);
    end
    b_resp_cfg = 2'b00;
  endtask

  task automatic test_rsp_hold_and_reset();
    int n;
    logic [31:0] d[$]; logic [1:0] r[$];
    set_waits(0, 0, 0, 0, 0);
    d = '{32'h5A5A_0001}; r = '{2'b00}; load_reads(d, r);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_poll = 1'b0; cmd_addr = 32'h8;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h5A5A_0001 || rsp_error !== 1'b0 ||
          rsp_polls !== PW'(1) || cmd_ready !== 1'b0) begin
        fails++; $display("FAIL rsp_hold[%0d]: vld=%b rdata=%h err=%b polls=%0d cmd_ready=%b, required 1/5a5a0001/0/1/0",
          i, rsp_valid, rsp_rdata, rsp_error, rsp_polls, cmd_ready);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    tests++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      fails++; $display("FAIL rsp_release: vld=%b cmd_ready=%b, required 0/1", rsp_valid, cmd_ready);
    end
    set_waits(0, 0, 0, 0, 40);
    cmd_valid = 1'b1; cmd_addr = 32'h4;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!req.r_ready && n < 20) begin @(negedge clk); n++; end
    tests++;
    if (req.r_ready !== 1'b1) begin fails++; $display("FAIL reach_wait_r: rready=%b, required 1", req.r_ready); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    set_waits(0, 0, 0, 0, 0);
    @(negedge clk);
    tests++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++; $display("FAIL midreset_hs: cmd_ready=%b rsp_valid=%b, required 1/0", cmd_ready, rsp_valid);
    end
    tests++;
    if ({req.aw_valid, req.w_valid, req.ar_valid, req.b_ready, req.r_ready} !== 5'b0 ||
        rsp_rdata !== 32'h0 || rsp_polls !== '0 || rsp_error !== 1'b0 || rsp_timeout !== 1'b0) begin
      fails++; $display("FAIL midreset_state: axi=%b rdata=%h polls=%0d err=%b to=%b, required zeros",
        {req.aw_valid, req.w_valid, req.ar_valid, req.b_ready, req.r_ready}, rsp_rdata, rsp_polls, rsp_error, rsp_timeout);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd; logic er, to; logic [PW-1:0] pl; int lat;
    logic [31:0] d[$]; logic [1:0] r[$];
    logic [31:0] addr, wdata, mask, match;
    logic [31:0] e_rd; logic e_er, e_to; int e_polls, e_aw, op, a0, w0;
    for (int it = 0; it < 30; it++) begin
      set_waits($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3));
      op    = $urandom_range(0, 2);
      addr  = {$urandom_range(0, 63), 2'b00};
      wdata = $urandom;
      mask  = 32'h1 << $urandom_range(0, 31);
      match = $urandom;
      b_resp_cfg = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
      d.delete(); r.delete();
      for (int k = 0; k < MP; k++) begin
        d.push_back($urandom);
        r.push_back(($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00);
      end
      load_reads(d, r);
      // Reference: outcome follows directly from the planned slave data
      e_rd = 32'h0; e_er = 1'b0; e_to = 1'b0; e_polls = 0; e_aw = 0;
      if (op == 0) begin
        e_er = b_resp_cfg[1]; e_aw = 1;
      end else if (op == 1) begin
        e_rd = d[0]; e_er = r[0][1]; e_polls = 1;
      end else begin
        for (int k = 0; k < MP; k++) begin
          e_polls = k + 1; e_rd = d[k];
          if (r[k][1]) begin e_er = 1'b1; break; end
          if ((d[k] & mask) == (match & mask)) break;
          if (k == MP - 1) e_to = 1'b1;
        end
      end
      a0 = ar_cnt; w0 = aw_cnt;
      run_cmd(op == 0, op == 2, addr, wdata, 4'hF, mask, match, rd, er, to, pl, lat);
      tests++;
      if (rd !== e_rd || er !== e_er || to !== e_to || pl !== PW'(e_polls)) begin
        fails++; $display("FAIL random[%0d] op=%0d: rdata=%h err=%b to=%b polls=%0d, required %h/%b/%b/%0d",
          it, op, rd, er, to, pl, e_rd, e_er, e_to, e_polls);
      end
      tests++;
      if (ar_cnt - a0 !== e_polls || aw_cnt - w0 !== e_aw) begin
        fails++; $display("FAIL random_beats[%0d]: ars=%0d aws=%0d, required %0d/%0d",
          it, ar_cnt - a0, aw_cnt - w0, e_polls, e_aw);
      end
      tests++;
      if ((e_aw == 1 && (last_awaddr !== addr || last_wdata !== wdata)) ||
          (e_aw == 0 && last_araddr !== addr)) begin
        fails++; $display("FAIL random_addr[%0d]: awaddr=%h wdata=%h araddr=%h, required addr %h data %h",
          it, last_awaddr, last_wdata, last_araddr, addr, wdata);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_poll_match();
    test_poll_timeout();
    test_backpressure();
    test_rsp_hold_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
